// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - two-port round-robin arbiter with lock/hold in front of a 1-cycle data memory
module data_mem_arbiter #(
    parameter int WORD_SIZE      = 64,
    parameter int DATA_ADDR_SIZE = 8,
    parameter int MAX_HOLD       = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      a_req,
    input  logic                      a_write,
    input  logic                      a_lock,
    input  logic [DATA_ADDR_SIZE-1:0] a_addr,
    input  logic [WORD_SIZE-1:0]      a_wdata,
    input  logic                      b_req,
    input  logic                      b_write,
    input  logic                      b_lock,
    input  logic [DATA_ADDR_SIZE-1:0] b_addr,
    input  logic [WORD_SIZE-1:0]      b_wdata,
    output logic                      a_gnt,
    output logic                      b_gnt,
    output logic                      a_rvalid,
    output logic                      b_rvalid,
    output logic [WORD_SIZE-1:0]      a_rdata,
    output logic [WORD_SIZE-1:0]      b_rdata,
    output logic                      mem_en,
    output logic                      mem_write,
    output logic [DATA_ADDR_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0]      mem_wdata,
    input  logic [WORD_SIZE-1:0]      mem_rdata
);

    localparam int               CNT_W   = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        HOLD_A,
        HOLD_B
    } state_t;

    state_t           r_state;
    logic             r_last_gnt;   // 0 = A, 1 = B
    logic [CNT_W-1:0] r_hold_cnt;
    logic             r_a_rvalid;
    logic             r_b_rvalid;

    logic             w_a_gnt;
    logic             w_b_gnt;
    logic             w_any_gnt;
    logic             w_continue;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_lock;
    logic             w_other_req;
    logic             w_stay;

    // A holding port wins only while it still requests; otherwise plain round-robin applies.
    always_comb begin
        w_a_gnt = 1'b0;
        w_b_gnt = 1'b0;
        if (rst_n) begin
            if (r_state == HOLD_A && a_req) begin
                w_a_gnt = 1'b1;
            end else if (r_state == HOLD_B && b_req) begin
                w_b_gnt = 1'b1;
            end else if (a_req && b_req) begin
                w_a_gnt = r_last_gnt;
                w_b_gnt = ~r_last_gnt;
            end else begin
                w_a_gnt = a_req;
                w_b_gnt = b_req;
            end
        end
    end

    assign w_any_gnt   = w_a_gnt | w_b_gnt;
    assign w_continue  = (w_a_gnt && r_state == HOLD_A) || (w_b_gnt && r_state == HOLD_B);
    assign w_cnt_next  = !w_continue            ? CNT_ONE :
                         (r_hold_cnt == CNT_MAX) ? CNT_MAX : r_hold_cnt + CNT_ONE;
    assign w_lock      = w_a_gnt ? a_lock : b_lock;
    assign w_other_req = w_a_gnt ? b_req  : a_req;
    // Count is judged after this grant so the owner gets exactly MAX_HOLD cycles under contention.
    assign w_stay      = w_any_gnt && w_lock && ((w_cnt_next < CNT_MAX) || !w_other_req);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_last_gnt <= 1'b1;
            r_hold_cnt <= '0;
            r_a_rvalid <= 1'b0;
            r_b_rvalid <= 1'b0;
        end else begin
            r_a_rvalid <= w_a_gnt;
            r_b_rvalid <= w_b_gnt;
            if (w_any_gnt) begin
                r_last_gnt <= w_b_gnt;
            end
            if (w_stay) begin
                r_state    <= w_a_gnt ? HOLD_A : HOLD_B;
                r_hold_cnt <= w_cnt_next;
            end else begin
                r_state    <= IDLE;
                r_hold_cnt <= '0;
            end
        end
    end

    assign a_gnt     = w_a_gnt;
    assign b_gnt     = w_b_gnt;
    assign mem_en    = w_any_gnt;
    assign mem_write = w_a_gnt ? a_write : (w_b_gnt ? b_write : 1'b0);
    assign mem_addr  = w_a_gnt ? a_addr  : (w_b_gnt ? b_addr  : '0);
    assign mem_wdata = w_a_gnt ? a_wdata : (w_b_gnt ? b_wdata : '0);

    // Gating with rst_n hides a response whose grant was cut off by reset.
    assign a_rvalid  = r_a_rvalid & rst_n;
    assign b_rvalid  = r_b_rvalid & rst_n;
    assign a_rdata   = a_rvalid ? mem_rdata : '0;
    assign b_rdata   = b_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - vector table plus scoreboard bench for data_mem_arbiter
module tb_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_req, a_write, a_lock, b_req, b_write, b_lock;
    logic [7:0]  a_addr, b_addr, mem_addr;
    logic [63:0] a_wdata, b_wdata, mem_wdata, mem_rdata, a_rdata, b_rdata;
    logic        a_gnt, b_gnt, a_rvalid, b_rvalid, mem_en, mem_write;
    logic        preload;

    always #5 clk = ~clk;

    data_mem_arbiter #(.WORD_SIZE(64), .DATA_ADDR_SIZE(8), .MAX_HOLD(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_write(a_write), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_req(b_req), .b_write(b_write), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
        .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
        .a_rdata(a_rdata), .b_rdata(b_rdata),
        .mem_en(mem_en), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Environment memory: registered read-before-write.
    logic [63:0] tb_mem [256];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) tb_mem[i] <= 64'd0;
            tb_mem[8'h10] <= 64'hDEAD;
        end else if (mem_en) begin
            mem_rdata <= tb_mem[mem_addr];
            if (mem_write) tb_mem[mem_addr] <= mem_wdata;
        end
    end

    typedef struct {
        logic        rst_n;
        logic        ar, aw, al;
        logic [7:0]  aa;
        logic [63:0] ad;
        logic        br, bw, bl;
        logic [7:0]  ba;
        logic [63:0] bd;
        logic        ea, eb;
    } vec_t;

    typedef struct {
        logic        av;
        logic        bv;
        logic [63:0] data;
    } rsp_t;

    logic [63:0] ref_mem [256];
    rsp_t        sb_q [$];
    vec_t        tbl [$];
    int          n_total = 0;
    int          n_bad   = 0;
    int          cyc     = 0;

    function automatic vec_t v(input logic r, input logic ar, input logic aw, input logic al,
                               input logic [7:0] aa, input logic [63:0] ad,
                               input logic br, input logic bw, input logic bl,
                               input logic [7:0] ba, input logic [63:0] bd,
                               input logic ea, input logic eb);
        vec_t t;
        t.rst_n = r; t.ar = ar; t.aw = aw; t.al = al; t.aa = aa; t.ad = ad;
        t.br = br; t.bw = bw; t.bl = bl; t.ba = ba; t.bd = bd; t.ea = ea; t.eb = eb;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input vec_t t);
        rsp_t        e;
        logic [63:0] exp_addr, exp_wdata;
        logic        exp_write;
        rst_n = t.rst_n;
        a_req = t.ar; a_write = t.aw; a_lock = t.al; a_addr = t.aa; a_wdata = t.ad;
        b_req = t.br; b_write = t.bw; b_lock = t.bl; b_addr = t.ba; b_wdata = t.bd;
        @(negedge clk);
        if (sb_q.size() > 0) e = sb_q.pop_front();
        else begin e.av = 1'b0; e.bv = 1'b0; e.data = 64'd0; end
        if (!t.rst_n) begin e.av = 1'b0; e.bv = 1'b0; end
        chk("a_rvalid", {63'd0, a_rvalid}, {63'd0, e.av});
        chk("b_rvalid", {63'd0, b_rvalid}, {63'd0, e.bv});
        chk("a_rdata", a_rdata, e.av ? e.data : 64'd0);
        chk("b_rdata", b_rdata, e.bv ? e.data : 64'd0);
        chk("a_gnt", {63'd0, a_gnt}, {63'd0, t.ea});
        chk("b_gnt", {63'd0, b_gnt}, {63'd0, t.eb});
        chk("mem_en", {63'd0, mem_en}, {63'd0, t.ea | t.eb});
        exp_write = t.ea ? t.aw : (t.eb ? t.bw : 1'b0);
        exp_addr  = t.ea ? {56'd0, t.aa} : (t.eb ? {56'd0, t.ba} : 64'd0);
        exp_wdata = t.ea ? t.ad : (t.eb ? t.bd : 64'd0);
        chk("mem_write", {63'd0, mem_write}, {63'd0, exp_write});
        chk("mem_addr", {56'd0, mem_addr}, exp_addr);
        chk("mem_wdata", mem_wdata, exp_wdata);
        e.av = t.ea; e.bv = t.eb; e.data = 64'd0;
        if (t.ea) begin
            e.data = ref_mem[t.aa];
            if (t.aw) ref_mem[t.aa] = t.ad;
        end else if (t.eb) begin
            e.data = ref_mem[t.ba];
            if (t.bw) ref_mem[t.ba] = t.bd;
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 64'd0;
        ref_mem[8'h10] = 64'hDEAD;
        preload = 1'b1;
        rst_n = 1'b0;
        a_req = 0; a_write = 0; a_lock = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_write = 0; b_lock = 0; b_addr = 0; b_wdata = 0;
        @(posedge clk); #1;
        preload = 1'b0;

        // reset, then single read, write-then-read, contention, lock fairness, lock release
        tbl.push_back(v(0, 0,0,0,8'h00,0,       0,0,0,8'h00,0,       0,0));
        tbl.push_back(v(0, 1,0,0,8'h10,0,       1,0,0,8'h03,0,       0,0));
        tbl.push_back(v(1, 0,0,0,8'h00,0,       0,0,0,8'h00,0,       0,0));
        tbl.push_back(v(1, 1,0,0,8'h10,0,       0,0,0,8'h00,0,       1,0));
        tbl.push_back(v(1, 0,0,0,8'h00,0,       0,0,0,8'h00,0,       0,0));
        tbl.push_back(v(1, 0,0,0,8'h00,0,       1,1,0,8'h03,64'h55,  0,1));
        tbl.push_back(v(1, 0,0,0,8'h00,0,       1,0,0,8'h03,0,       0,1));
        for (int i = 0; i < 4; i++)
            tbl.push_back(v(1, 1,0,0,8'h10,0,   1,0,0,8'h03,0,       (i % 2) == 0, (i % 2) == 1));
        for (int i = 0; i < 5; i++)
            tbl.push_back(v(1, 1,0,1,8'h10,0,   1,0,0,8'h03,0,       i < 4, i == 4));
        tbl.push_back(v(1, 1,0,1,8'h10,0,       1,0,0,8'h03,0,       1,0));
        tbl.push_back(v(1, 0,0,0,8'h00,0,       0,0,0,8'h00,0,       0,0));
        tbl.push_back(v(1, 1,0,0,8'h10,0,       1,0,1,8'h03,0,       0,1));
        tbl.push_back(v(1, 1,0,0,8'h10,0,       1,0,0,8'h03,0,       0,1));
        tbl.push_back(v(1, 1,0,0,8'h10,0,       1,0,0,8'h03,0,       1,0));
        tbl.push_back(v(1, 0,0,0,8'h00,0,       0,0,0,8'h00,0,       0,0));
        foreach (tbl[i]) step(tbl[i]);

        // A locked with B idle keeps the port indefinitely; a late B request waits one more cycle
        for (int i = 0; i < 8; i++)
            step(v(1, 1,0,1,8'h10,0,            0,0,0,8'h00,0,       1,0));
        step(v(1, 1,0,1,8'h10,0,                1,0,0,8'h03,0,       1,0));
        step(v(1, 1,0,1,8'h10,0,                1,0,0,8'h03,0,       0,1));
        step(v(1, 1,0,1,8'h10,0,                1,0,0,8'h03,0,       1,0));
        step(v(1, 0,0,0,8'h00,0,                0,0,0,8'h00,0,       0,0));

        // reset right after a write grant: write stays, response dropped, A wins first contention
        step(v(1, 1,1,0,8'h20,64'h1234,         0,0,0,8'h00,0,       1,0));
        step(v(0, 1,0,0,8'h20,0,                1,0,0,8'h10,0,       0,0));
        step(v(1, 1,0,0,8'h20,0,                1,0,0,8'h10,0,       1,0));
        step(v(1, 0,0,0,8'h00,0,                1,0,0,8'h10,0,       0,1));
        step(v(1, 0,0,0,8'h00,0,                0,0,0,8'h00,0,       0,0));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
